// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter stage.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } pc_state_e;

    localparam int unsigned PC_INC     = 4;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC select and redirect-alignment check.
module next_pc_calc
    import pc_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic [AW-1:0] pc,
    input  logic [DW-1:0] imm,
    input  logic [DW-1:0] rs1_data,
    input  logic          is_branch,
    input  logic          is_jal,
    input  logic          is_jalr,
    input  logic          ps_sel,
    output logic [AW-1:0] target,
    output logic          misaligned
);

    localparam int unsigned XW = (AW > DW) ? AW : DW;

    logic [XW-1:0] imm_x;
    logic [XW-1:0] rs1_x;
    logic [AW-1:0] imm_a;
    logic [AW-1:0] rs1_a;
    logic [AW-1:0] jalr_sum;
    logic          redirect;

    // Immediate is sign-extended, jalr base zero-extended, then both folded to AW bits.
    assign imm_x    = XW'($signed(imm));
    assign rs1_x    = XW'(rs1_data);
    assign imm_a    = imm_x[AW-1:0];
    assign rs1_a    = rs1_x[AW-1:0];
    assign jalr_sum = rs1_a + imm_a;

    always_comb begin
        target   = pc + AW'(PC_INC);
        redirect = 1'b0;
        if (is_jalr) begin
            target   = {jalr_sum[AW-1:1], 1'b0};
            redirect = 1'b1;
        end else if (is_jal || (is_branch && ps_sel)) begin
            target   = pc + imm_a;
            redirect = 1'b1;
        end
    end

    // Sequential targets stay aligned because pc itself is always aligned.
    assign misaligned = redirect && ((target[1:0] & ALIGN_MASK) != 2'b00);

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: holds the PC, issues fetch requests, selects next PC and traps misaligned redirects.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned    AW       = 32,
    parameter int unsigned    DW       = 32,
    parameter logic [AW-1:0]  RESET_PC = AW'(32'h0000_0000),
    parameter logic [AW-1:0]  TRAP_PC  = AW'(32'h0000_0100)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          pc_valid,
    input  logic          pc_ready,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_plus4,
    input  logic          exec_done,
    input  logic          is_branch,
    input  logic          is_jal,
    input  logic          is_jalr,
    input  logic          ps_sel,
    input  logic [DW-1:0] imm,
    input  logic [DW-1:0] rs1_data,
    output logic          trap,
    output logic [AW-1:0] epc
);

    pc_state_e     state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] epc_q, epc_d;
    logic          valid_q, valid_d;
    logic          trap_q, trap_d;
    logic [AW-1:0] target;
    logic          misaligned;

    next_pc_calc #(
        .AW (AW),
        .DW (DW)
    ) u_next_pc_calc (
        .pc         (pc_q),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .is_branch  (is_branch),
        .is_jal     (is_jal),
        .is_jalr    (is_jalr),
        .ps_sel     (ps_sel),
        .target     (target),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            valid_q <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            valid_q <= valid_d;
            trap_q  <= trap_d;
        end
    end

    // Next-state and registered-output values; pc only moves on a completed EXEC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        valid_d = 1'b0;
        trap_d  = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
                valid_d = 1'b1;
            end
            FETCH: begin
                valid_d = 1'b1;
                if (pc_ready) begin
                    state_d = EXEC;
                    valid_d = 1'b0;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    state_d = FETCH;
                    valid_d = 1'b1;
                    if (misaligned) begin
                        pc_d   = TRAP_PC;
                        epc_d  = pc_q;
                        trap_d = 1'b1;
                    end else begin
                        pc_d = target;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign pc_valid = valid_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_q + AW'(PC_INC);
    assign trap     = trap_q;
    assign epc      = epc_q;

    // Protocol misuse by the core: stray completions and ambiguous control flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(exec_done && (state_q != EXEC)));
            assert (!(exec_done && ($countones({is_jalr, is_jal, is_branch}) > 1)));
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Randomized self-checking bench for pc_unit against a spec-level next-PC model.
module tb_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_valid;
    logic        pc_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        exec_done;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        ps_sel;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        trap;
    logic [31:0] epc;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    logic [31:0] m_epc;

    pc_unit #(
        .AW       (32),
        .DW       (32),
        .RESET_PC (RESET_PC),
        .TRAP_PC  (TRAP_PC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_valid  (pc_valid),
        .pc_ready  (pc_ready),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .exec_done (exec_done),
        .is_branch (is_branch),
        .is_jal    (is_jal),
        .is_jalr   (is_jalr),
        .ps_sel    (ps_sel),
        .imm       (imm),
        .rs1_data  (rs1_data),
        .trap      (trap),
        .epc       (epc)
    );

    always #5 clk = ~clk;

    // Reference: new PC/trap/epc from the architectural rules applied to m_pc.
    task automatic model_step(input logic br, input logic jl, input logic jr, input logic ps,
                              input logic [31:0] im, input logic [31:0] rs,
                              output logic exp_trap);
        logic [31:0] t;
        bit          redirect;
        redirect = 1'b1;
        if (jr)             t = (rs + im) & 32'hFFFF_FFFE;
        else if (jl)        t = m_pc + im;
        else if (br && ps)  t = m_pc + im;
        else begin
            t        = m_pc + 32'd4;
            redirect = 1'b0;
        end
        exp_trap = redirect && (t % 4 != 0);
        if (exp_trap) begin
            m_epc = m_pc;
            m_pc  = TRAP_PC;
        end else begin
            m_pc = t;
        end
    endtask

    task automatic wait_fetch();
        int k = 0;
        while (!pc_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!pc_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_fetch: pc_valid=%0b required 1 within 20 cycles", pc_valid);
        end
    endtask

    // Drives one fetch handshake (after 'delay' not-ready cycles) and one completion.
    task automatic issue(input logic br, input logic jl, input logic jr, input logic ps,
                         input logic [31:0] im, input logic [31:0] rs, input int delay);
        wait_fetch();
        pc_ready = 1'b0;
        repeat (delay) @(negedge clk);
        pc_ready = 1'b1;
        @(negedge clk);
        pc_ready  = 1'b0;
        is_branch = br;
        is_jal    = jl;
        is_jalr   = jr;
        ps_sel    = ps;
        imm       = im;
        rs1_data  = rs;
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        ps_sel    = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic br, input logic jl, input logic jr,
                                 input logic ps, input logic [31:0] im, input logic [31:0] rs,
                                 input int delay);
        logic exp_trap;
        model_step(br, jl, jr, ps, im, rs, exp_trap);
        issue(br, jl, jr, ps, im, rs, delay);
        n_cmp++;
        if (pc !== m_pc) begin
            n_err++;
            $display("FAIL %s pc: got %h required %h", name, pc, m_pc);
        end
        n_cmp++;
        if (trap !== exp_trap) begin
            n_err++;
            $display("FAIL %s trap: got %b required %b", name, trap, exp_trap);
        end
        n_cmp++;
        if (epc !== m_epc) begin
            n_err++;
            $display("FAIL %s epc: got %h required %h", name, epc, m_epc);
        end
        n_cmp++;
        if (pc_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s pc_valid: got %b required 1", name, pc_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pc !== RESET_PC || pc_plus4 !== RESET_PC + 32'd4) begin
            n_err++;
            $display("FAIL reset pc: got %h/%h required %h/%h", pc, pc_plus4, RESET_PC, RESET_PC + 32'd4);
        end
        n_cmp++;
        if (pc_valid !== 1'b0 || trap !== 1'b0 || epc !== 32'd0) begin
            n_err++;
            $display("FAIL reset outputs: got valid=%b trap=%b epc=%h required 0/0/0", pc_valid, trap, epc);
        end
        rst = 1'b0;
        n_cmp++;
        if (pc_valid !== 1'b0) begin
            n_err++;
            $display("FAIL boot_valid: got %b required 0", pc_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (pc_valid !== 1'b1 || pc !== RESET_PC) begin
            n_err++;
            $display("FAIL first_request: got valid=%b pc=%h required 1/%h", pc_valid, pc, RESET_PC);
        end
        m_pc  = RESET_PC;
        m_epc = 32'd0;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (pc !== 32'(4 * i) || pc_plus4 !== 32'(4 * i + 4)) begin
                n_err++;
                $display("FAIL seq_pc%0d: got %h/%h required %h/%h", i, pc, pc_plus4, 4 * i, 4 * i + 4);
            end
            run_and_check("seq", 1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom, 0);
        end
    endtask

    task automatic test_branch();
        run_and_check("jal_to_40", 1'b0, 1'b1, 1'b0, 1'b0, 32'h40 - m_pc, 32'd0, 0);
        run_and_check("br_taken", 1'b1, 1'b0, 1'b0, 1'b1, -32'sd16, 32'd0, 1);
        run_and_check("jal_back", 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 0);
        run_and_check("br_not_taken", 1'b1, 1'b0, 1'b0, 1'b0, -32'sd16, 32'd0, 0);
        n_cmp++;
        if (pc !== 32'h44) begin
            n_err++;
            $display("FAIL br_not_taken_abs: got %h required 00000044", pc);
        end
        run_and_check("br_nt_misaligned", 1'b1, 1'b0, 1'b0, 1'b0, 32'h3, 32'd0, 0);
    endtask

    task automatic test_jalr();
        logic [31:0] link;
        wait_fetch();
        link = pc_plus4;
        n_cmp++;
        if (link !== m_pc + 32'd4) begin
            n_err++;
            $display("FAIL jalr_link: got %h required %h", link, m_pc + 32'd4);
        end
        run_and_check("jalr", 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h1001, 0);
        n_cmp++;
        if (pc !== 32'h1010 || trap !== 1'b0) begin
            n_err++;
            $display("FAIL jalr_abs: got pc=%h trap=%b required 00001010/0", pc, trap);
        end
    endtask

    task automatic test_trap();
        run_and_check("to_20", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h20, 0);
        run_and_check("jal_mis", 1'b0, 1'b1, 1'b0, 1'b0, 32'h6, 32'd0, 0);
        n_cmp++;
        if (pc !== 32'h100 || epc !== 32'h20 || trap !== 1'b1) begin
            n_err++;
            $display("FAIL trap_abs: got pc=%h epc=%h trap=%b required 00000100/00000020/1", pc, epc, trap);
        end
        @(negedge clk);
        n_cmp++;
        if (trap !== 1'b0 || epc !== 32'h20) begin
            n_err++;
            $display("FAIL trap_pulse: got trap=%b epc=%h required 0/00000020", trap, epc);
        end
    endtask

    task automatic test_stall();
        wait_fetch();
        pc_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (pc !== m_pc || pc_valid !== 1'b1) begin
                n_err++;
                $display("FAIL stall%0d: got pc=%h valid=%b required %h/1", i, pc, pc_valid, m_pc);
            end
        end
        run_and_check("after_stall", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 0);
        run_and_check("to_top", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFFC, 2);
        n_cmp++;
        if (pc_plus4 !== 32'd0) begin
            n_err++;
            $display("FAIL top_plus4: got %h required 00000000", pc_plus4);
        end
        run_and_check("wrap", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            logic        br, jl, jr, ps;
            logic [31:0] im, rs;
            int          kind;
            kind = int'($urandom_range(0, 3));
            br = (kind == 1);
            jl = (kind == 2);
            jr = (kind == 3);
            ps = 1'($urandom);
            im = 32'($signed(int'($urandom_range(0, 255)) - 128) * 4);
            if ($urandom_range(0, 7) == 0) im = im + 32'($urandom_range(1, 3));
            rs = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
            run_and_check("random", br, jl, jr, ps, im, rs, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid();
        run_and_check("pre_to_20", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h20, 0);
        run_and_check("pre_trap", 1'b0, 1'b1, 1'b0, 1'b0, 32'h2, 32'd0, 0);
        wait_fetch();
        pc_ready = 1'b1;
        @(negedge clk);
        pc_ready  = 1'b0;
        is_jal    = 1'b1;
        imm       = 32'h6;
        exec_done = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        is_jal    = 1'b0;
        n_cmp++;
        if (pc !== RESET_PC || trap !== 1'b0 || epc !== 32'd0 || pc_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got pc=%h trap=%b epc=%h valid=%b required %h/0/0/0",
                     pc, trap, epc, pc_valid, RESET_PC);
        end
        rst   = 1'b0;
        m_pc  = RESET_PC;
        m_epc = 32'd0;
        run_and_check("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 0);
    endtask

    initial begin
        rst       = 1'b1;
        pc_ready  = 1'b0;
        exec_done = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        ps_sel    = 1'b0;
        imm       = 32'd0;
        rs1_data  = 32'd0;
        m_pc      = RESET_PC;
        m_epc     = 32'd0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_branch();
        test_jalr();
        test_trap();
        test_stall();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter stage for the single-cycle core: holds the architectural PC and presents it to instruction memory over a valid/ready handshake. On instruction completion it computes the next PC from the branch-compare result (`ps_sel`), jump flags, immediate and `rs1_data`, and checks alignment. Misaligned targets redirect to a trap vector. It sits directly downstream of the branch comparator and upstream of instruction fetch.

## Interface
Parameters:
- `AW`, 32, address/PC width
- `DW`, 32, data width of `rs1_data`/`imm`
- `RESET_PC`, 32'h0000_0000, PC loaded on reset (must be 4-byte aligned)
- `TRAP_PC`, 32'h0000_0100, PC loaded on misaligned-target trap (must be 4-byte aligned)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock
- `rst`  in  1  synchronous active-high reset
- `pc_valid`  out  1  `pc` is a fetch request
- `pc_ready`  in  1  instruction memory accepts request
- `pc`  out  AW  current PC
- `pc_plus4`  out  AW  `pc + 4`, link value for jal/jalr
- `exec_done`  in  1  current instruction completes this cycle; next-PC inputs valid
- `is_branch`  in  1  conditional branch
- `is_jal`  in  1  jal
- `is_jalr`  in  1  jalr
- `ps_sel`  in  1  branch condition true (from comparator)
- `imm`  in  DW  sign-extended immediate
- `rs1_data`  in  DW  jalr base
- `trap`  out  1  one-cycle pulse: misaligned target taken
- `epc`  out  AW  PC of faulting instruction, held until next trap

## Operation
- States: `BOOT`, `FETCH`, `EXEC`.
- `BOOT`: `pc_valid`=0; unconditionally -> `FETCH` next cycle.
- `FETCH`: `pc_valid`=1, `pc` stable; on `pc_valid && pc_ready` -> `EXEC`. `pc` must not change while `pc_valid` high and `pc_ready` low.
- `EXEC`: `pc_valid`=0; wait for `exec_done`; on it, load next PC (or trap PC), -> `FETCH`.
- Next-PC select, priority `is_jalr` > `is_jal` > `is_branch && ps_sel` > sequential:
  - jalr: `(rs1_data + imm) & ~1`
  - jal / taken branch: `pc + imm`
  - otherwise: `pc + 4`
- Arithmetic is modulo 2^AW; DW→AW truncation when DW>AW. `pc + 4` from `32'hFFFF_FFFC` wraps to 0, no trap.
- Misaligned: redirect target `[1:0] != 0` (jalr checks after bit-0 clear, i.e. bit 1). Then `pc` <= `TRAP_PC`, `epc` <= faulting `pc`, `trap`=1 for one cycle. Not-taken branch never traps even if `pc+imm` misaligned.
- `exec_done` outside `EXEC`: ignored (assertion flags it). More than one of `is_jalr/is_jal/is_branch`: priority applies, assertion flags it.

## Timing
- Reset values: state `BOOT`, `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC+4`, `pc_valid`=0, `trap`=0, `epc`=0.
- First request: `pc_valid`=1 in the second cycle after `rst` deasserts.
- `pc_valid` and `pc` registered; `pc_plus4` combinational from `pc`.
- Next PC visible on `pc` the cycle after `exec_done`, with `pc_valid`=1 same cycle; `trap` asserted in that same cycle.
- Handshake accepted in the cycle `pc_ready` is seen high; zero-wait memory gives FETCH 1 cycle, loop min 2 cycles/instr plus exec.
- `rst` mid-operation (any state, pending handshake, same cycle as `exec_done`): reset wins; no trap, `epc` cleared.

## Structure
- Package `pc_pkg`: state enum `pc_state_e {BOOT, FETCH, EXEC}`, `PC_INC` = 4, `ALIGN_MASK` = 2'b11.
- One combinational sub-module `next_pc_calc`: inputs pc, imm, rs1_data, flags, ps_sel; outputs target and `misaligned`. Top holds FSM, PC, epc, trap registers.

## Test plan
- Reset, `pc_ready`=1, sequential instrs -> `pc` 0x0, 0x4, 0x8 across three `exec_done`; `pc_valid`=0 during reset and `BOOT`.
- `pc`=0x40, `is_branch`=1, `ps_sel`=1, `imm`=-16 -> 0x30; with `ps_sel`=0 -> 0x44.
- `is_jalr`, `rs1_data`=0x1001, `imm`=0x10 -> 0x1010, no trap; `pc_plus4` = old `pc+4`.
- `pc`=0x20, `is_jal`, `imm`=0x6 -> `trap` one cycle, `pc`=0x100, `epc`=0x20.
- `pc_ready` low 5 cycles in `FETCH` -> `pc` stable, state stays `FETCH`; `pc`=0xFFFF_FFFC sequential -> 0x0.
- `rst` in same cycle as misaligning `exec_done` -> `pc`=`RESET_PC`, `trap`=0, `epc`=0.
